// File: rtl/alu_seq.sv
// Registered ALU with single-cycle ops and iterative unsigned MUL/DIV behind a start/busy/done handshake.
// Optional build macro: ALU_CARRY_CHAIN_EN (ADD/SUB/RSUB take cin for multi-word ADC/SBC chaining).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  // Returns {overflow, carry, sum}.
  function automatic logic [WIDTH+1:0] f_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             ci);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    return {(x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]), s[WIDTH], s[WIDTH-1:0]};
  endfunction

  // Returns {overflow, not-borrow, difference}; ci=1 means no borrow in.
  function automatic logic [WIDTH+1:0] f_sub(input logic [WIDTH-1:0] m,
                                             input logic [WIDTH-1:0] s,
                                             input logic             ci);
    logic [WIDTH:0] d;
    d = {1'b0, m} + {1'b0, ~s} + {{WIDTH{1'b0}}, ci};
    return {(m[WIDTH-1] != s[WIDTH-1]) && (d[WIDTH-1] != m[WIDTH-1]), d[WIDTH], d[WIDTH-1:0]};
  endfunction

  state_t             r_state;
  logic [SHW-1:0]     r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_out_hi;
  logic [3:0]         r_flags;
  logic               r_dz;

  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_add_ci;
  logic               w_sub_ci;
  logic [SHW-1:0]     w_amt;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_o;
  logic [2*WIDTH-1:0] w_rot;
  logic [WIDTH:0]     w_sh;

  logic               w_accept_mc;
  logic               w_last;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_df;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_hi_nx;
  logic [WIDTH-1:0]   w_lo_nx;

`ifdef ALU_CARRY_CHAIN_EN
  assign w_add_ci = cin;
  assign w_sub_ci = cin;
`else
  // cin stays on the port for pin compatibility but has no effect in this build.
  assign w_add_ci = cin & 1'b0;
  assign w_sub_ci = 1'b1;
`endif

  assign w_amt = op_a[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    w_rot = '0;
    w_sh  = '0;
    case (mode)
      4'h0: {w_o, w_c, w_res} = f_add(op_a, op_b, w_add_ci);
      4'h1: {w_o, w_c, w_res} = f_sub(op_a, op_b, w_sub_ci);
      4'h2: w_res = op_a;
      4'h3: w_res = op_b;
      4'h4: w_res = op_a & op_b;
      4'h5: w_res = op_a | op_b;
      4'h6: w_res = op_a ^ op_b;
      4'h7: {w_o, w_c, w_res} = f_sub(op_b, op_a, w_sub_ci);
      4'h8: {w_o, w_c, w_res} = f_add(op_b, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0);
      4'h9: {w_o, w_c, w_res} = f_sub(op_b, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b1);
      4'hA: begin
        w_rot = {op_b, op_b} << w_amt;
        w_res = w_rot[2*WIDTH-1:WIDTH];
      end
      4'hB: begin
        w_rot = {op_b, op_b} >> w_amt;
        w_res = w_rot[WIDTH-1:0];
      end
      // The extra bit beside the operand catches the last bit shifted out.
      4'hC: begin
        w_sh         = {1'b0, op_b} << w_amt;
        {w_c, w_res} = w_sh;
      end
      4'hD: begin
        w_sh         = {op_b, 1'b0} >> w_amt;
        {w_res, w_c} = w_sh;
      end
      default: ;
    endcase
  end

  assign w_accept_mc = start && (r_state == S_IDLE) && (mode[3:1] == 3'b111);
  assign w_last      = (r_cnt == SHW'(WIDTH - 1));

  // MUL: {r_hi,r_lo} is the shift-add product register, r_lo starts as the multiplier.
  // DIV: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
  assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_df  = w_div_sh - {1'b0, r_opa};
  assign w_div_ok  = ~w_div_df[WIDTH];

  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_state == S_MUL) begin
      w_hi_nx = w_mul_sum[WIDTH:1];
      w_lo_nx = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      w_hi_nx = w_div_ok ? w_div_df[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], w_div_ok};
    end
  end

  // Iteration datapath: no reset needed, it is always reloaded on an accepted start.
  always_ff @(posedge clk) begin
    if (w_accept_mc) begin
      r_opa <= op_a;
      r_opb <= op_b;
      r_hi  <= '0;
      r_lo  <= op_b;
    end else if (r_state != S_IDLE) begin
      r_hi <= w_hi_nx;
      r_lo <= w_lo_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_out_hi <= '0;
      r_flags  <= '0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (mode == 4'hE) begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
            end else if (mode == 4'hF) begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_out    <= w_res;
              r_out_hi <= '0;
              r_flags  <= {(w_res == '0), w_c, w_res[WIDTH-1], w_o};
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_out    <= w_lo_nx;
            r_out_hi <= w_hi_nx;
            r_flags  <= {(w_lo_nx == '0), (w_hi_nx != '0), w_lo_nx[WIDTH-1], (w_hi_nx != '0)};
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // A zero divisor still runs the full iteration count so latency is fixed.
            if (r_opa == '0) begin
              r_out    <= '1;
              r_out_hi <= r_opb;
              r_flags  <= 4'b0010;
              r_dz     <= 1'b1;
            end else begin
              r_out    <= w_lo_nx;
              r_out_hi <= w_hi_nx;
              r_flags  <= {(w_lo_nx == '0), 1'b0, w_lo_nx[WIDTH-1], 1'b0};
              r_dz     <= 1'b0;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign out    = r_out;
  assign out_hi = r_out_hi;
  assign flags  = r_flags;
  assign dz     = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): expected results queued at issue, compared on done.
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_CARRY_CHAIN_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   mode = 4'h0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic [3:0]   flags;
  logic         dz;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
    .cin(cin), .busy(busy), .done(done), .out(out), .out_hi(out_hi), .flags(flags), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] h;
    logic [3:0]   f;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic m_dz = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ovf(input int v);
    return (v > 127) || (v < -128);
  endfunction

  function automatic exp_t model(input logic [3:0] m, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
    exp_t e;
    int r, sa, sbv, amt, ci;
    bit cc, oo;
    logic [W-1:0] t;
    e = '0; cc = 1'b0; oo = 1'b0; r = 0;
    e.z = m_dz;
    amt = int'(a[2:0]);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    case (m)
      4'h0: begin ci = CC ? int'(c) : 0; r = int'(a) + int'(b) + ci; cc = (r > 255); oo = ovf(sa + sbv + ci); end
      4'h1: begin ci = CC ? int'(c) : 1; r = int'(a) - int'(b) - (1 - ci); cc = (r >= 0); oo = ovf(sa - sbv - (1 - ci)); end
      4'h2: r = int'(a);
      4'h3: r = int'(b);
      4'h4: r = int'(a & b);
      4'h5: r = int'(a | b);
      4'h6: r = int'(a ^ b);
      4'h7: begin ci = CC ? int'(c) : 1; r = int'(b) - int'(a) - (1 - ci); cc = (r >= 0); oo = ovf(sbv - sa - (1 - ci)); end
      4'h8: begin r = int'(b) + 1; cc = (r > 255); oo = ovf(sbv + 1); end
      4'h9: begin r = int'(b) - 1; cc = (r >= 0); oo = ovf(sbv - 1); end
      4'hA: begin t = b; repeat (amt) t = {t[W-2:0], t[W-1]}; r = int'(t); end
      4'hB: begin t = b; repeat (amt) t = {t[0], t[W-1:1]}; r = int'(t); end
      4'hC: begin r = int'(b) << amt; if (amt != 0) cc = b[W-amt]; end
      4'hD: begin r = int'(b) >> amt; if (amt != 0) cc = b[amt-1]; end
      4'hE: begin r = int'(a) * int'(b); e.h = W'(r >> 8); cc = (e.h != 0); oo = cc; end
      default: begin
        if (a == 0) begin r = 255; e.h = b; e.z = 1'b1; end
        else begin r = int'(b) / int'(a); e.h = W'(int'(b) % int'(a)); e.z = 1'b0; end
      end
    endcase
    e.o = r[W-1:0];
    e.f = {(e.o == 0), cc, e.o[W-1], oo};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) chk("spurious_done", 32'(done), 32'(0));
      else begin
        e = sb.pop_front();
        chk("out", 32'(out), 32'(e.o));
        chk("out_hi", 32'(out_hi), 32'(e.h));
        chk("flags", 32'(flags), 32'(e.f));
        chk("dz", 32'(dz), 32'(e.z));
      end
    end
  end

  // Issues one op from the current negedge and returns at the negedge where done is seen,
  // so the next call issues back-to-back. poke pulses an ignored start while busy.
  task automatic run_op(input logic [3:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int poke);
    int lat, nb, el;
    bit seen;
    exp_t e;
    mode = m; op_a = a; op_b = b; cin = c; start = 1'b1;
    e = model(m, a, b, c);
    m_dz = e.z;
    sb.push_back(e);
    el = (m >= 4'hE) ? W + 1 : 1;
    lat = 0; nb = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else if (busy) nb++;
      start = 1'b0;
      if (!seen) begin
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); mode = 4'($urandom);
        if (lat == poke) start = 1'b1;
      end
    end
    chk("latency", 32'(lat), 32'(el));
    chk("busy_cycles", 32'(nb), 32'(el - 1));
    chk("busy_at_done", 32'(busy), 32'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_out"}, 32'(out), 32'(0));
    chk({tag, "_out_hi"}, 32'(out_hi), 32'(0));
    chk({tag, "_flags"}, 32'(flags), 32'(0));
    chk({tag, "_dz"}, 32'(dz), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");

    run_op(4'h0, 8'h7F, 8'h01, 1'b0, 0);
    chk("add_ovf_out", 32'(out), 32'h80);
    chk("add_ovf_flags", 32'(flags), 32'b0011);
    run_op(4'h1, 8'h05, 8'h07, 1'b1, 0);
    chk("sub_out", 32'(out), 32'hFE);
    chk("sub_flags", 32'(flags), 32'b0010);
    run_op(4'hA, 8'h01, 8'h81, 1'b0, 0);
    chk("rol_out", 32'(out), 32'h03);
    chk("rol_flags", 32'(flags), 32'b0000);

    run_op(4'hE, 8'h10, 8'h20, 1'b0, 3);
    chk("mul_lo", 32'(out), 32'h00);
    chk("mul_hi", 32'(out_hi), 32'h02);
    chk("mul_flags", 32'(flags), 32'b1101);
    run_op(4'hF, 8'h07, 8'h64, 1'b0, 2);
    chk("div_q", 32'(out), 32'h0E);
    chk("div_r", 32'(out_hi), 32'h02);
    chk("div_dz", 32'(dz), 32'(0));
    run_op(4'hF, 8'h00, 8'h33, 1'b0, 5);
    chk("divz_q", 32'(out), 32'hFF);
    chk("divz_r", 32'(out_hi), 32'h33);
    chk("divz_dz", 32'(dz), 32'(1));
    run_op(4'h2, 8'h00, 8'h00, 1'b0, 0);
    chk("dz_hold", 32'(dz), 32'(1));

    run_op(4'hC, 8'h00, 8'h80, 1'b0, 0);
    run_op(4'hC, 8'h01, 8'h80, 1'b0, 0);
    run_op(4'hD, 8'h00, 8'h01, 1'b0, 0);
    run_op(4'hD, 8'h01, 8'h01, 1'b0, 0);
    run_op(4'hD, 8'h07, 8'h80, 1'b0, 0);
    run_op(4'hB, 8'h09, 8'h01, 1'b0, 0);
    run_op(4'h8, 8'h00, 8'hFF, 1'b0, 0);
    run_op(4'h9, 8'h00, 8'h80, 1'b0, 0);
    run_op(4'h7, 8'h80, 8'h01, 1'b1, 0);
    run_op(4'hE, 8'hFF, 8'hFF, 1'b0, 7);
    run_op(4'hF, 8'h01, 8'hC8, 1'b0, 1);

    run_op(4'h0, 8'hFF, 8'h00, 1'b1, 0);
    chk("cc_add_out", 32'(out), CC ? 32'h00 : 32'hFF);
    chk("cc_add_c", 32'(flags[2]), CC ? 32'(1) : 32'(0));

    // Abort a MUL four cycles in with a one-cycle reset pulse.
    run_op(4'hF, 8'h00, 8'hA5, 1'b0, 0);
    @(negedge clk);
    mode = 4'hE; op_a = 8'h10; op_b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    sb.delete();
    m_dz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done), 32'(0));
    end
    run_op(4'h0, 8'h01, 8'h01, 1'b0, 0);
    chk("post_reset_add", 32'(out), 32'h02);

    for (int i = 0; i < 80; i++)
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom),
             $urandom_range(1, 7));

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
